// File: rtl/shifter_pipe_if.sv
// Handshake bundle for shifter_pipe: request side (in_*) and result side (out_*).
// The slave modport is the shifter's view; the master modport is the producer/consumer view.
interface shifter_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_tag
  );
endinterface

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR): stage k applies a shift of 2^k when amt bit k is set.
// Each stage stalls only when it is full and its downstream cannot take data, so bubbles collapse.
module shifter_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH),
  parameter int TAG_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  shifter_pipe_if.slave bus
);

  logic             v_q    [SHW];
  logic [WIDTH-1:0] data_q [SHW];
  logic [WIDTH-1:0] data_d [SHW];
  logic [SHW-1:0]   amt_q  [SHW];
  logic [1:0]       mode_q [SHW];
  logic [TAG_W-1:0] tag_q  [SHW];
  logic             zero_q;

  logic             up_v    [SHW];
  logic [WIDTH-1:0] up_data [SHW];
  logic [SHW-1:0]   up_amt  [SHW];
  logic [1:0]       up_mode [SHW];
  logic [TAG_W-1:0] up_tag  [SHW];

  logic [SHW:0]     rdy;

  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       mode,
    input int unsigned      n
  );
    logic [WIDTH-1:0] r;
    case (mode)
      2'b00:   r = d << n;
      2'b01:   r = d >> n;
      2'b10:   r = $unsigned($signed(d) >>> n);
      default: r = (d >> n) | (d << (WIDTH - n));
    endcase
    return r;
  endfunction

  // A stage can load if it is empty or everything downstream of it can move.
  always_comb begin
    rdy      = '0;
    rdy[SHW] = bus.out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      rdy[k] = !v_q[k] || rdy[k+1];
    end
  end

  generate
    for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
      if (gi == 0) begin : g_src_in
        assign up_v[gi]    = bus.in_valid;
        assign up_data[gi] = bus.in_data;
        assign up_amt[gi]  = bus.in_amt;
        assign up_mode[gi] = bus.in_mode;
        assign up_tag[gi]  = bus.in_tag;
      end else begin : g_src_prev
        assign up_v[gi]    = v_q[gi-1];
        assign up_data[gi] = data_q[gi-1];
        assign up_amt[gi]  = amt_q[gi-1];
        assign up_mode[gi] = mode_q[gi-1];
        assign up_tag[gi]  = tag_q[gi-1];
      end

      always_comb begin
        data_d[gi] = up_data[gi];
        if (up_amt[gi][gi]) begin
          data_d[gi] = shift_step(up_data[gi], up_mode[gi], 32'd1 << gi);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q[gi]    <= 1'b0;
          data_q[gi] <= '0;
          amt_q[gi]  <= '0;
          mode_q[gi] <= '0;
          tag_q[gi]  <= '0;
        end else if (rdy[gi]) begin
          v_q[gi]    <= up_v[gi];
          data_q[gi] <= data_d[gi];
          amt_q[gi]  <= up_amt[gi];
          mode_q[gi] <= up_mode[gi];
          tag_q[gi]  <= up_tag[gi];
        end
      end
    end
  endgenerate

  // Zero flag travels with the final-stage data so it costs no output-path logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (rdy[SHW-1]) begin
      zero_q <= (data_d[SHW-1] == '0);
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = v_q[SHW-1];
  assign bus.out_data  = data_q[SHW-1];
  assign bus.out_zero  = zero_q;
  assign bus.out_tag   = tag_q[SHW-1];

endmodule

// File: doc/shifter_pipe.md
# shifter_pipe

Parametrised, pipelined barrel shifter for the execute datapath, replacing the fixed 16-bit combinational SLL/SRA shifter. It supports four modes (SLL, SRL, SRA, ROR) and one register stage per shift-amount bit. It has a valid/ready handshake on both sides with bubble-collapsing backpressure. It sustains one operation per cycle and carries a sideband tag alongside each operation.

## Interface
Parameters:
- WIDTH, 16: data width. Must be a power of two, ≥ 4.
- SHW, $clog2(WIDTH): shift-amount width and pipeline depth. Derived; do not override.
- TAG_W, 4: sideband tag width, passed through unmodified.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input operation present.
- in_ready  out  1  block can accept an operation this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  SHW  shift amount, 0..WIDTH-1.
- in_mode  in  2  operation: 00 = SLL, 01 = SRL, 10 = SRA, 11 = ROR.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_data  out  WIDTH  shifted result.
- out_zero  out  1  asserted when out_data == 0.
- out_tag  out  TAG_W  tag of the operation that produced out_data.

## Operation
- The pipeline has SHW stages, S0..S(SHW-1). Each stage holds: v, data, remaining amt bits, mode, tag.
- Shift logic (combinational, feeding stage k's register):
  - If amt bit k is 1, stage k shifts by 2^k; otherwise it passes the data through.
  - S0 takes its input from the in_* ports. Sk takes its input from S(k-1).
- Shift rules per step of n = 2^k:
  - SLL: {d[WIDTH-1-n:0], n zeros}.
  - SRL: {n zeros, d[WIDTH-1:n]}.
  - SRA: {n copies of d[WIDTH-1], d[WIDTH-1:n]}. The sign is taken from the current stage's data, which preserves the original sign.
  - ROR: {d[n-1:0], d[WIDTH-1:n]}.
- Amount 0: out_data = in_data for every mode.
- The final stage S(SHW-1) drives out_data, out_tag and out_valid directly.
- out_zero is registered in the final stage, computed from that stage's next data.
- Handshake (bubble collapsing):
  - rdy_final = !v_final || out_ready.
  - rdy_k = !v_k || rdy_(k+1).
  - in_ready = rdy_0.
  - Stage k loads from its upstream when rdy_k is 1. Its v becomes the upstream valid (in_valid for S0).
  - When rdy_k is 0, stage k holds all of its fields.
- An input is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- Stalled stages hold their data bit-stable. An empty stage upstream of a stall still fills, so bubbles collapse.
- in_ready is combinational from out_ready and the stage valids. There is no combinational path from in_valid to any output.
- Reset clears all v to 0 and all data, amt, mode and tag registers to 0. out_zero resets to 0.
- Asserting rst mid-operation discards every in-flight operation. No result is emitted for them.

## Timing
- Latency is SHW cycles, measured from the accept edge to out_valid, with no stall. Example: WIDTH=16 gives 4 cycles.
- Throughput is 1 operation per cycle while out_ready = 1.
- Simultaneous accept and consume in the same cycle with a full pipeline is legal, and throughput is preserved.
- With out_ready held at 0:
  - After SHW accepts, in_ready drops to 0.
  - out_data and out_tag stay stable until consumed.
- Reset values of outputs: in_ready = 1 (all stages empty), out_valid = 0, out_data = 0, out_zero = 0, out_tag = 0.
- Results emerge strictly in acceptance order. Tags identify them.

## Test plan
All scenarios use WIDTH=16.
- Mode sweep. Stimulus, back to back, with out_ready = 1:
  - SLL 0x0001 by 15 → 0x8000.
  - SRL 0x8000 by 4 → 0x0800.
  - SRA 0x8000 by 4 → 0xF800.
  - ROR 0x1234 by 4 → 0x4123.
  - Required: each result arrives 4 cycles after its accept, on consecutive cycles, with tags in order.
- Zero flag and amount 0:
  - SRL 0x0001 by 1 → 0x0000 with out_zero = 1.
  - SRA 0x7FFF by 0 → 0x7FFF with out_zero = 0.
- Backpressure: hold out_ready = 0 and drive 6 back-to-back valid inputs.
  - Required: exactly 4 are accepted, then in_ready = 0.
  - out_data stays stable while stalled.
  - Releasing out_ready drains all 6 in order, with no loss and no duplicates.
- Bubble collapse: inject ops at cycles 0 and 2, hold out_ready = 0 until both are inside, then release.
  - Required: the two results appear on consecutive cycles.
- Reset mid-flight: accept 3 ops, assert rst asynchronously between clock edges.
  - Required: out_valid drops to 0 immediately, in_ready becomes 1, and no stale result appears after rst is released.
- Randomised: 10k ops with random mode, amount, data and out_ready, checked against a reference model (result, out_zero, tag order).
